// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select codes,
// FSM state encoding and the register-match helper used by the forwarding muxes.
package hazard_ctrl_pkg;

  localparam int unsigned RegAddrWidth = 5;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdMem = 2'b01;
  localparam logic [1:0] FwdWb  = 2'b10;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } hz_state_e;

  // A later stage supplies rs only if it writes a non-x0 destination equal to rs.
  function automatic logic rd_match(logic we, logic [RegAddrWidth-1:0] rd,
                                    logic [RegAddrWidth-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX-stage source register.
// MEM-stage results are newer than WB results, so MEM wins.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [RegAddrWidth-1:0] rs_i,
  input  logic [RegAddrWidth-1:0] rd_mem_i,
  input  logic                    regwrite_mem_i,
  input  logic [RegAddrWidth-1:0] rd_wb_i,
  input  logic                    regwrite_wb_i,
  output logic [1:0]              fwd_o
);

  always_comb begin
    fwd_o = FwdReg;
    if (rd_match(regwrite_mem_i, rd_mem_i, rs_i)) begin
      fwd_o = FwdMem;
    end else if (rd_match(regwrite_wb_i, rd_wb_i, rs_i)) begin
      fwd_o = FwdWb;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: forwarding, load-use bubble, memory-wait
// freeze with watchdog, and branch flush. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] rs1_id,
  input  logic [RegAddrWidth-1:0] rs2_id,
  input  logic                    rs1_used_id,
  input  logic                    rs2_used_id,
  input  logic [RegAddrWidth-1:0] rs1_ex,
  input  logic [RegAddrWidth-1:0] rs2_ex,
  input  logic [RegAddrWidth-1:0] rd_ex,
  input  logic                    memread_ex,
  input  logic                    branch_taken_ex,
  input  logic [RegAddrWidth-1:0] rd_mem,
  input  logic                    regwrite_mem,
  input  logic [RegAddrWidth-1:0] rd_wb,
  input  logic                    regwrite_wb,
  input  logic                    mem_req_mem,
  input  logic                    mem_ready,
  output logic [1:0]              forwarda,
  output logic [1:0]              forwardb,
  output logic                    stall_pc,
  output logic                    stall_if_id,
  output logic                    stall_id_ex,
  output logic                    stall_ex_mem,
  output logic                    stall_mem_wb,
  output logic                    bubble_id_ex,
  output logic                    flush_if_id,
  output logic                    mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             perf_lu_stalls,
  output logic [31:0]             perf_mem_stall_cycles,
  output logic [31:0]             perf_flushes
`endif
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(MEM_TIMEOUT - 1);

  hz_state_e        state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit, frz, lu;

  hazard_ctrl_fwd_sel u_fwd_a (
    .rs_i           (rs1_ex),
    .rd_mem_i       (rd_mem),
    .regwrite_mem_i (regwrite_mem),
    .rd_wb_i        (rd_wb),
    .regwrite_wb_i  (regwrite_wb),
    .fwd_o          (forwarda)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .rs_i           (rs2_ex),
    .rd_mem_i       (rd_mem),
    .regwrite_mem_i (regwrite_mem),
    .rd_wb_i        (rd_wb),
    .regwrite_wb_i  (regwrite_wb),
    .fwd_o          (forwardb)
  );

  assign tmo_hit = (cnt_q == TmoLast);
  assign frz = ((state_q == StRun) && mem_req_mem && !mem_ready) ||
               ((state_q == StMemWait) && !mem_ready && !tmo_hit);
  assign lu  = memread_ex && (rd_ex != '0) &&
               ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      StRun: begin
        if (mem_req_mem && !mem_ready) begin
          state_d = StMemWait;
          cnt_d   = '0;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
        end else if (tmo_hit) begin
          // Give up on the stuck access and let the pipeline advance.
          state_d = StRun;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (!rst) begin
      if (frz) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (branch_taken_ex) begin
        // Wrong-path ID instruction dies, so a load-use against it is moot.
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (lu) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_timeout = tmo_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_frz_q, perf_flush_q;
  logic        lu_applied;

  // A load-use stall is the only case that stalls the PC without freezing EX/MEM.
  assign lu_applied = stall_pc && !stall_ex_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q    <= '0;
      perf_frz_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      if (lu_applied && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 32'd1;
      if (stall_ex_mem && (perf_frz_q != '1)) perf_frz_q <= perf_frz_q + 32'd1;
      if (flush_if_id && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_lu_stalls        = perf_lu_q;
  assign perf_mem_stall_cycles = perf_frz_q;
  assign perf_flushes          = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic, checked
// against a reference model that tracks each memory access by its frozen-cycle age.
module tb_hazard_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned TmoW       = 3;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_id, rs2_id;
    logic       rs1_used, rs2_used;
    logic [4:0] rs1_ex, rs2_ex, rd_ex;
    logic       memread, br;
    logic [4:0] rd_mem;
    logic       rw_mem;
    logic [4:0] rd_wb;
    logic       rw_wb;
    logic       req, ready;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic [4:0]  stalls;
    logic        bubble, flush, tmo;
    logic [31:0] p_lu, p_frz, p_fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic       rs1_used_id, rs2_used_id, memread_ex, branch_taken_ex;
  logic       regwrite_mem, regwrite_wb, mem_req_mem, mem_ready;
  logic [1:0] forwarda, forwardb;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic       bubble_id_ex, flush_if_id, mem_timeout;
  logic [31:0] perf_lu_stalls, perf_mem_stall_cycles, perf_flushes;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_TIMEOUT (MemTimeout),
    .TMO_W       (TmoW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs1_used_id     (rs1_used_id),
    .rs2_used_id     (rs2_used_id),
    .rs1_ex          (rs1_ex),
    .rs2_ex          (rs2_ex),
    .rd_ex           (rd_ex),
    .memread_ex      (memread_ex),
    .branch_taken_ex (branch_taken_ex),
    .rd_mem          (rd_mem),
    .regwrite_mem    (regwrite_mem),
    .rd_wb           (rd_wb),
    .regwrite_wb     (regwrite_wb),
    .mem_req_mem     (mem_req_mem),
    .mem_ready       (mem_ready),
    .forwarda        (forwarda),
    .forwardb        (forwardb),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .stall_id_ex     (stall_id_ex),
    .stall_ex_mem    (stall_ex_mem),
    .stall_mem_wb    (stall_mem_wb),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id),
    .mem_timeout     (mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_stalls        (perf_lu_stalls),
    .perf_mem_stall_cycles (perf_mem_stall_cycles),
    .perf_flushes          (perf_flushes)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign perf_lu_stalls        = '0;
  assign perf_mem_stall_cycles = '0;
  assign perf_flushes          = '0;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Reference model: an outstanding access is frozen for at most MemTimeout cycles total.
  bit          m_pending = 0;
  int          m_age = 0;
  bit          m_tmo = 0;
  longint      m_lu = 0, m_frz = 0, m_fl = 0;

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
    if (s.rw_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'b01;
    if (s.rw_wb && s.rd_wb != 0 && s.rd_wb == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   frz, lu;
    @(posedge clk);
    #1;
    rst = s.rst; rs1_id = s.rs1_id; rs2_id = s.rs2_id;
    rs1_used_id = s.rs1_used; rs2_used_id = s.rs2_used;
    rs1_ex = s.rs1_ex; rs2_ex = s.rs2_ex; rd_ex = s.rd_ex;
    memread_ex = s.memread; branch_taken_ex = s.br;
    rd_mem = s.rd_mem; regwrite_mem = s.rw_mem; rd_wb = s.rd_wb; regwrite_wb = s.rw_wb;
    mem_req_mem = s.req; mem_ready = s.ready;

    frz = !s.ready && (m_pending ? (m_age < MemTimeout) : s.req);
    lu  = s.memread && s.rd_ex != 0 &&
          ((s.rs1_used && s.rs1_id == s.rd_ex) || (s.rs2_used && s.rs2_id == s.rd_ex));
    e = '0;
    e.fa = ref_fwd(s, s.rs1_ex);
    e.fb = ref_fwd(s, s.rs2_ex);
    e.tmo = m_tmo;
    e.p_lu = m_lu[31:0]; e.p_frz = m_frz[31:0]; e.p_fl = m_fl[31:0];
    if (!s.rst) begin
      if (frz) e.stalls = 5'b11111;
      else if (s.br) begin e.flush = 1; e.bubble = 1; end
      else if (lu) begin e.stalls = 5'b11000; e.bubble = 1; end
    end
    exp_q.push_back(e);

    if (s.rst) begin
      m_pending = 0; m_age = 0; m_tmo = 0; m_lu = 0; m_frz = 0; m_fl = 0;
    end else begin
      if (frz) begin
        m_pending = 1;
        m_age++;
      end else begin
        if (m_pending && !s.ready) m_tmo = 1;
        m_pending = 0;
        m_age = 0;
      end
      if (e.stalls == 5'b11000) m_lu = sat_inc(m_lu);
      if (frz) m_frz = sat_inc(m_frz);
      if (e.flush) m_fl = sat_inc(m_fl);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("forwarda", 32'(forwarda), 32'(e.fa));
      chk("forwardb", 32'(forwardb), 32'(e.fb));
      chk("stalls", 32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb}),
          32'(e.stalls));
      chk("bubble_id_ex", 32'(bubble_id_ex), 32'(e.bubble));
      chk("flush_if_id", 32'(flush_if_id), 32'(e.flush));
      chk("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
`ifdef HAZARD_PERF_EN
      chk("perf_lu_stalls", perf_lu_stalls, e.p_lu);
      chk("perf_mem_stall_cycles", perf_mem_stall_cycles, e.p_frz);
      chk("perf_flushes", perf_flushes, e.p_fl);
`endif
    end
  end

  initial begin
    stim_t s;
    s = '0;
    rst = 1; rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
    rs1_ex = 0; rs2_ex = 0; rd_ex = 0; memread_ex = 0; branch_taken_ex = 0;
    rd_mem = 0; regwrite_mem = 0; rd_wb = 0; regwrite_wb = 0;
    mem_req_mem = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    // Reset state
    s.rst = 1; apply(s); s.rst = 0; apply(s);
    // Forwarding priority
    s.rd_mem = 5; s.rw_mem = 1; s.rd_wb = 5; s.rw_wb = 1; s.rs1_ex = 5; s.rs2_ex = 0; apply(s);
    s.rw_mem = 0; apply(s);
    s = '0;
    // Load-use: one bubble, then with rs2 unused
    s.memread = 1; s.rd_ex = 7; s.rs2_id = 7; s.rs2_used = 1; apply(s);
    s = '0; apply(s);
    s.memread = 1; s.rd_ex = 7; s.rs2_id = 7; s.rs2_used = 0; apply(s);
    s = '0;
    // Memory wait three cycles, then ready
    s.req = 1; repeat (3) apply(s);
    s.ready = 1; apply(s);
    s = '0; apply(s);
    // Watchdog
    s.req = 1; repeat (7) apply(s);
    s = '0; s.ready = 1; repeat (2) apply(s);
    // Branch beats load-use
    s.br = 1; s.memread = 1; s.rd_ex = 3; s.rs1_id = 3; s.rs1_used = 1; apply(s);
    s = '0;
    // Branch held through a freeze
    s.req = 1; s.br = 1; repeat (2) apply(s);
    s.ready = 1; apply(s);
    s = '0; s.ready = 1; apply(s);
    // Reset on the second wait cycle
    s = '0; s.req = 1; repeat (2) apply(s);
    s.rst = 1; apply(s);
    s = '0; s.ready = 1; repeat (2) apply(s);

    // Random traffic over a small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 199) == 0);
      s.rs1_id   = 5'($urandom_range(0, 3));
      s.rs2_id   = 5'($urandom_range(0, 3));
      s.rs1_used = 1'($urandom);
      s.rs2_used = 1'($urandom);
      s.rs1_ex   = 5'($urandom_range(0, 3));
      s.rs2_ex   = 5'($urandom_range(0, 3));
      s.rd_ex    = 5'($urandom_range(0, 3));
      s.memread  = 1'($urandom);
      s.br       = ($urandom_range(0, 5) == 0);
      s.rd_mem   = 5'($urandom_range(0, 3));
      s.rw_mem   = 1'($urandom);
      s.rd_wb    = 5'($urandom_range(0, 3));
      s.rw_wb    = 1'($urandom);
      s.req      = ($urandom_range(0, 2) == 0);
      s.ready    = ($urandom_range(0, 3) != 0);
      apply(s);
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
